// File: rtl/gigex_rx_cmd_controller_pkg.sv
// Shared definitions for the GigEx receive command path: framing constants,
// the receive FSM state type, the buffered command word layout and a header check.
package gigex_rx_cmd_controller_pkg;

  localparam logic [3:0] HDR_SYNC    = 4'hC;
  localparam int         CMD_LEN     = 32;
  localparam int         FRAME_BYTES = 5;

  typedef enum logic {
    IDLE,
    PAYLOAD
  } rx_state_e;

  // One buffered command: target module alongside the assembled word.
  typedef struct packed {
    logic [1:0]         module_idx;
    logic [CMD_LEN-1:0] data;
  } cmd_word_t;

  // A header is valid when it carries the sync nibble, zero reserved bits
  // and addresses an existing frontend module.
  function automatic logic hdr_ok(input logic [7:0] hdr, input int unsigned nmod);
    return (hdr[7:4] == HDR_SYNC) && (hdr[3:2] == 2'b00) && ({30'd0, hdr[1:0]} < nmod);
  endfunction

endpackage

// File: rtl/gigex_rx_cmd_controller_cmd_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count. The caller
// guarantees wr_en_i never fires on a full FIFO without a same-cycle read and
// rd_en_i never fires on an empty one.
module cmd_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  // Storage array: written on push, never reset.
  // NOTE: the array is left out of reset on purpose; occupancy is tracked by
  // count_q, so stale contents are never presented and no reset fan-out is needed.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;

endmodule

// File: rtl/gigex_rx_cmd_controller.sv
// GigEx Rx byte stream to framed 32-bit module commands. Bytes are registered,
// framed by a two-state FSM, assembled MSB first, buffered in a FWFT FIFO and
// presented as a valid/ready stream. The Rx full flag throttles GigEx.
module gigex_rx_cmd_controller
  import gigex_rx_cmd_controller_pkg::*;
#(
  parameter int          CHANNEL  = 3,
  parameter int          DEPTH    = 8,
  parameter int          TIMEOUT  = 1024,
  parameter int unsigned NMODULES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  q_i,
  input  logic        n_rx_i,
  input  logic [2:0]  rc_i,
  output logic [7:0]  n_rf_o,
  output logic [31:0] cmd_data_o,
  output logic [1:0]  cmd_module_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic        frame_err_o,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] err_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [7:0]  q_q;
  logic        n_rx_q;
  logic [2:0]  rc_q;

  rx_state_e   state_q;
  logic [1:0]  idx_q;
  logic [1:0]  module_q;
  logic [23:0] shift_q;
  logic [TW-1:0] to_cnt_q;
  logic        push_q;
  cmd_word_t   push_word_q;
  logic        frame_err_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;
  logic [7:0]  n_rf_q;

  cmd_word_t   fifo_rd_word;
  logic        fifo_empty;
  logic        fifo_full;
  logic [AW:0] fifo_count;

  logic        accept;
  logic        pop;
  logic        push_ok;
  logic        overflow;

  assign accept   = !n_rx_q && (rc_q == 3'(CHANNEL));
  assign pop      = cmd_valid_o && cmd_ready_i;
  assign push_ok  = push_q && (!fifo_full || pop);
  assign overflow = push_q && fifo_full && !pop;

  // Input capture: every decision below uses these registered copies.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      n_rx_q <= 1'b1;
      rc_q   <= '0;
    end else begin
      q_q    <= q_i;
      n_rx_q <= n_rx_i;
      rc_q   <= rc_i;
    end
  end

  // Framing FSM: header check, payload shift, idle timeout, push request and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      module_q    <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= overflow;
      unique case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (accept) begin
            if (hdr_ok(q_q, NMODULES)) begin
              state_q  <= PAYLOAD;
              idx_q    <= '0;
              module_q <= q_q[1:0];
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            to_cnt_q <= '0;
            shift_q  <= {shift_q[15:0], q_q};
            if (idx_q == 2'(FRAME_BYTES - 2)) begin
              push_q      <= 1'b1;
              push_word_q <= '{module_idx: module_q, data: {shift_q, q_q}};
              state_q     <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
            frame_err_q <= 1'b1;
            to_cnt_q    <= '0;
            state_q     <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating statistics: successful pushes and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (push_ok && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (frame_err_q && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  // Rx full flag: our channel reads not-full only while two or more entries are free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_rf_q <= '0;
    end else begin
      n_rf_q          <= '0;
      n_rf_q[CHANNEL] <= (fifo_count <= (AW+1)'(DEPTH - 2));
    end
  end

  cmd_sync_fifo #(
    .WIDTH ($bits(cmd_word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push_ok),
    .wr_data_i (push_word_q),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_word),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  assign cmd_valid_o  = !fifo_empty;
  assign cmd_data_o   = cmd_valid_o ? fifo_rd_word.data : '0;
  assign cmd_module_o = cmd_valid_o ? fifo_rd_word.module_idx : '0;
  assign frame_err_o  = frame_err_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign err_cnt_o    = err_cnt_q;
  assign n_rf_o       = n_rf_q;

endmodule

// File: tb/tb_gigex_rx_cmd_controller.sv
// Bench for gigex_rx_cmd_controller: directed byte streams drive the Rx port,
// expected commands go into a queue and a negedge monitor compares each
// delivered beat; counters and flags are checked at quiet points.
module tb_gigex_rx_cmd_controller;

  localparam int CH      = 3;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  q = '0;
  logic        n_rx = 1'b1;
  logic [2:0]  rc = '0;
  logic [7:0]  n_rf;
  logic [31:0] cmd_data;
  logic [1:0]  cmd_module;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;
  logic [33:0] exp_q [$];

  gigex_rx_cmd_controller #(
    .CHANNEL (CH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .NMODULES(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .q_i          (q),
    .n_rx_i       (n_rx),
    .rc_i         (rc),
    .n_rf_o       (n_rf),
    .cmd_data_o   (cmd_data),
    .cmd_module_o (cmd_module),
    .cmd_valid_o  (cmd_valid),
    .cmd_ready_i  (cmd_ready),
    .frame_err_o  (frame_err),
    .frame_cnt_o  (frame_cnt),
    .err_cnt_o    (err_cnt)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare each transferred beat against the scoreboard, count error pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_seen++;
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_without_expectation", 64'(exp_q.size()), 64'd1);
        end else begin
          check("cmd_beat", {30'd0, cmd_module, cmd_data}, {30'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic drive(input logic [7:0] b, input logic [2:0] ch, input logic v);
    @(posedge clk);
    #1;
    q    = b;
    rc   = ch;
    n_rx = ~v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 3'(CH), 1'b0);
  endtask

  task automatic send_frame(input logic [1:0] m, input logic [31:0] w, input bit expect_ok,
                            input bit tail);
    if (expect_ok) exp_q.push_back({m, w});
    drive({4'hC, 2'b00, m}, 3'(CH), 1'b1);
    for (int i = 3; i >= 0; i--) drive(w[8*i +: 8], 3'(CH), 1'b1);
    if (tail) idle(1);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    n_rx  = 1'b1;
    exp_q.delete();
    err_seen = 0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic drain_check(input string name);
    cmd_ready = 1'b1;
    idle(DEPTH + 6);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    #10;
    check("rst_n_rf", 64'(n_rf), 64'h00);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_data", 64'(cmd_data), 64'd0);
    check("rst_err", 64'(frame_err), 64'd0);
    check("rst_counters", {32'd0, frame_cnt, err_cnt}, 64'd0);
    do_reset();
    check("n_rf_after_reset", 64'(n_rf), 64'h08);

    // 1: single frame, latency check
    send_frame(2'd1, 32'hDEADBEEF, 1'b1, 1'b0);
    drive(8'h00, 3'(CH), 1'b0);  // edge N: last byte captured
    @(posedge clk); #1;          // edge N+1
    check("t1_valid_n1", 64'(cmd_valid), 64'd0);
    @(posedge clk); #1;          // edge N+2
    check("t1_valid_n2", 64'(cmd_valid), 64'd1);
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    drain_check("t1_drained");

    // 2: bad header then good frame
    do_reset();
    drive(8'h51, 3'(CH), 1'b1);
    idle(4);
    check("t2_err_pulse", 64'(err_seen), 64'd1);
    check("t2_err_cnt", 64'(err_cnt), 64'd1);
    send_frame(2'd2, 32'h01234567, 1'b1, 1'b1);
    drain_check("t2_drained");
    check("t2_frame_cnt", 64'(frame_cnt), 64'd1);

    // 3: timeout inside a partial frame
    do_reset();
    drive(8'hC0, 3'(CH), 1'b1);
    drive(8'hAA, 3'(CH), 1'b1);
    drive(8'hBB, 3'(CH), 1'b1);
    idle(1);
    idle(TIMEOUT - 10);
    check("t3_no_early_timeout", 64'(err_cnt), 64'd0);
    idle(20);
    check("t3_timeout_err", 64'(err_cnt), 64'd1);
    check("t3_timeout_pulse", 64'(err_seen), 64'd1);
    send_frame(2'd3, 32'hCAFEF00D, 1'b1, 1'b1);
    drain_check("t3_drained");
    check("t3_frame_cnt", 64'(frame_cnt), 64'd1);

    // 4: overflow with consumer stalled
    do_reset();
    cmd_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++)
      send_frame(2'(i), 32'h1000_0000 + 32'(i), i < DEPTH, 1'b1);
    idle(6);
    check("t4_frame_cnt", 64'(frame_cnt), 64'(DEPTH));
    check("t4_err_cnt", 64'(err_cnt), 64'd1);
    check("t4_n_rf_full", 64'(n_rf), 64'h00);
    check("t4_valid_stalled", 64'(cmd_valid), 64'd1);
    drain_check("t4_drained");
    check("t4_n_rf_free", 64'(n_rf), 64'h08);

    // 5: other-channel bytes interleaved
    do_reset();
    drive(8'hC2, 3'(CH), 1'b1);
    drive(8'hC0, 3'd0, 1'b1);
    drive(8'h12, 3'(CH), 1'b1);
    drive(8'h99, 3'(CH), 1'b0);
    drive(8'h34, 3'(CH), 1'b1);
    drive(8'hAA, 3'd0, 1'b1);
    drive(8'h56, 3'(CH), 1'b1);
    drive(8'h78, 3'(CH), 1'b1);
    exp_q.push_back({2'd2, 32'h12345678});
    drain_check("t5_drained");
    check("t5_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t5_err_cnt", 64'(err_cnt), 64'd0);
    check("t5_other_n_rf", 64'(n_rf & 8'hF7), 64'h00);

    // 6: reset mid-frame discards FIFO and partial frame
    do_reset();
    cmd_ready = 1'b0;
    send_frame(2'd0, 32'h55AA55AA, 1'b1, 1'b1);
    drive(8'hC1, 3'(CH), 1'b1);
    drive(8'h11, 3'(CH), 1'b1);
    drive(8'h22, 3'(CH), 1'b1);
    drive(8'h33, 3'(CH), 1'b1);
    idle(1);
    check("t6_pre_reset_valid", 64'(cmd_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    err_seen = 0;
    #1;
    check("t6_rst_valid", 64'(cmd_valid), 64'd0);
    check("t6_rst_data", {30'd0, cmd_module, cmd_data}, 64'd0);
    check("t6_rst_flags", {47'd0, frame_err, n_rf}, 64'd0);
    check("t6_rst_counters", {32'd0, frame_cnt, err_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    idle(3);
    send_frame(2'd3, 32'h89ABCDEF, 1'b1, 1'b1);
    drain_check("t6_drained");
    check("t6_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t6_err_cnt", 64'(err_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
